// File: rtl/ddr_definitions.sv
// ddr_definitions
//   Shared game-state encoding for the DDR design. stateGenerator drives a
//   STATE_BITS+1 wide state bus; consumers compare against these constants.
package ddr_definitions;

    localparam int STATE_BITS = 1;

    typedef logic [STATE_BITS:0] state_t;

    localparam state_t STATE_MENU  = 2'd0;
    localparam state_t STATE_GAME  = 2'd1;
    localparam state_t STATE_PAUSE = 2'd2;
    localparam state_t STATE_END   = 2'd3;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clock_divider_toggle.sv
// clk_div_toggle
//   Half-period counter with a registered toggle output. Counts 0..HALF-1
//   while en is high; on the wrap cycle it flips toggle and raises tick
//   (combinational, same cycle as the wrap) for downstream phase logic.
//   Ports:
//     clk    in   system clock, rising edge
//     reset  in   synchronous, active-high; clears counter and toggle
//     en     in   advance the counter this cycle; low holds everything
//     clr    in   synchronous clear, same effect as reset
//     toggle out  square wave, period 2*HALF cycles, driven from a flop
//     tick   out  high on the cycle the counter wraps (en qualified)
module clk_div_toggle
    import ddr_definitions::*;
#(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic toggle,
    output logic tick
);

    localparam int CW = cnt_width(HALF);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt    <= '0;
            toggle <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt    <= '0;
                toggle <= ~toggle;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_divider.sv
// clock_divider
//   Derives phase-aligned 4/2/1 Hz square waves for game timing and a
//   free-running display multiplex clock. The slow chain runs only in
//   STATE_GAME, freezes in STATE_PAUSE and is cleared in any other state.
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   synchronous, active-high, highest priority
//     state        in   game state from stateGenerator
//     fourHz_CLK   out  4 Hz, 50% duty
//     twoHz_CLK    out  2 Hz, 50% duty
//     oneHz_CLK    out  1 Hz, 50% duty
//     display_CLK  out  DISPLAY_HZ, 50% duty, independent of state
module clock_divider
    import ddr_definitions::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int DISPLAY_HZ  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STATE_BITS:0] state,
    output logic                fourHz_CLK,
    output logic                twoHz_CLK,
    output logic                oneHz_CLK,
    output logic                display_CLK
);

    localparam int HALF4 = CLK_FREQ_HZ / 8;
    localparam int HALFD = CLK_FREQ_HZ / (2 * DISPLAY_HZ);

    logic       slow_en;
    logic       slow_clr;
    logic       tick4;
    logic       tickd_unused;
    logic [1:0] ph;

    // PAUSE is neither enabled nor cleared, so the whole slow chain holds.
    assign slow_en  = (state == STATE_GAME);
    assign slow_clr = (state != STATE_GAME) && (state != STATE_PAUSE);

    clk_div_toggle #(.HALF(HALF4)) u_c4 (
        .clk    (clk),
        .reset  (reset),
        .en     (slow_en),
        .clr    (slow_clr),
        .toggle (fourHz_CLK),
        .tick   (tick4)
    );

    clk_div_toggle #(.HALF(HALFD)) u_cd (
        .clk    (clk),
        .reset  (reset),
        .en     (1'b1),
        .clr    (1'b0),
        .toggle (display_CLK),
        .tick   (tickd_unused)
    );

    // Phase is tested before its increment: the very first tick after a
    // clear flips all three outputs high together, so every 1 Hz rising
    // edge lands on 2 Hz and 4 Hz rising edges.
    always_ff @(posedge clk) begin
        if (reset || slow_clr) begin
            ph        <= 2'd0;
            twoHz_CLK <= 1'b0;
            oneHz_CLK <= 1'b0;
        end else if (tick4) begin
            ph <= ph + 2'd1;
            if (!ph[0])
                twoHz_CLK <= ~twoHz_CLK;
            if (ph == 2'd0)
                oneHz_CLK <= ~oneHz_CLK;
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider with CLK_FREQ_HZ=800, DISPLAY_HZ=100
// (HALF4=100, HALFD=4). Inputs change and outputs are sampled 1 time unit
// after a rising edge; "cycle N" means the state right after edge N.
module tb_clock_divider;
    import ddr_definitions::*;

    logic                clk = 1'b0;
    logic                reset;
    logic [STATE_BITS:0] state;
    logic                four, two, one, disp;

    int tests  = 0;
    int errors = 0;

    clock_divider #(.CLK_FREQ_HZ(800), .DISPLAY_HZ(100)) dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .fourHz_CLK  (four),
        .twoHz_CLK   (two),
        .oneHz_CLK   (one),
        .display_CLK (disp)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_slow(input string tag, input logic e4, input logic e2, input logic e1);
        chk({tag, ".four"}, four, e4);
        chk({tag, ".two"},  two,  e2);
        chk({tag, ".one"},  one,  e1);
    endtask

    // Hold reset for two edges, then release into the given state.
    task automatic restart(input state_t s);
        reset = 1'b1;
        state = STATE_MENU;
        step(2);
        reset = 1'b0;
        state = s;
    endtask

    initial begin
        logic p4, p2, p1;
        int   rises;

        // Reset state
        reset = 1'b1;
        state = STATE_GAME;
        step(2);
        chk_slow("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.disp", disp, 1'b0);

        // Scenario 1: GAME from reset
        reset = 1'b0;
        step(99);   chk_slow("g99",  1'b0, 1'b0, 1'b0);
        step(1);    chk_slow("g100", 1'b1, 1'b1, 1'b1);
        step(99);   chk("g199.four", four, 1'b1);
        step(1);    chk_slow("g200", 1'b0, 1'b1, 1'b1);
        step(100);  chk_slow("g300", 1'b1, 1'b0, 1'b1);
        step(200);  chk_slow("g500", 1'b1, 1'b1, 1'b0);
        step(399);  chk("g899.one", one, 1'b0);
        step(1);    chk_slow("g900", 1'b1, 1'b1, 1'b1);

        // Display clock in MENU; slow chain stays cleared
        restart(STATE_MENU);
        step(3);    chk("m3.disp",  disp, 1'b0);
        step(1);    chk("m4.disp",  disp, 1'b1);
        step(3);    chk("m7.disp",  disp, 1'b1);
        step(1);    chk("m8.disp",  disp, 1'b0);
        step(4);    chk("m12.disp", disp, 1'b1);
        step(200);  chk_slow("m212", 1'b0, 1'b0, 1'b0);

        // Pause holds everything, resume continues mid-count
        restart(STATE_GAME);
        step(250);  chk_slow("p250", 1'b0, 1'b1, 1'b1);
        state = STATE_PAUSE;
        step(1000); chk_slow("pause", 1'b0, 1'b1, 1'b1);
        state = STATE_GAME;
        step(49);   chk("res49.four", four, 1'b0);
        step(1);    chk_slow("res50", 1'b1, 1'b0, 1'b1);

        // Tick coinciding with entry into PAUSE is suppressed
        restart(STATE_GAME);
        step(99);
        state = STATE_PAUSE;
        step(1);    chk("sup.four", four, 1'b0);
        step(50);   chk("sup50.four", four, 1'b0);
        state = STATE_GAME;
        step(1);    chk_slow("sup.res", 1'b1, 1'b1, 1'b1);

        // One cycle of MENU clears the slow chain
        restart(STATE_GAME);
        step(250);
        state = STATE_MENU;
        step(1);    chk_slow("menu.clr", 1'b0, 1'b0, 1'b0);
        state = STATE_GAME;
        step(99);   chk("menu99.four", four, 1'b0);
        step(1);    chk_slow("menu100", 1'b1, 1'b1, 1'b1);

        // END also clears
        restart(STATE_GAME);
        step(150);
        state = STATE_END;
        step(1);    chk_slow("end.clr", 1'b0, 1'b0, 1'b0);

        // Reset mid-count, then rerun
        restart(STATE_GAME);
        step(350);  chk_slow("r350", 1'b1, 1'b0, 1'b1);
        chk("r350.disp", disp, 1'b1);
        reset = 1'b1;
        step(1);    chk_slow("r.hit", 1'b0, 1'b0, 1'b0);
        chk("r.hit.disp", disp, 1'b0);
        reset = 1'b0;
        step(100);  chk_slow("rr100", 1'b1, 1'b1, 1'b1);
        step(100);  chk_slow("rr200", 1'b0, 1'b1, 1'b1);

        // Alignment: each 1 Hz rise must coincide with 2 Hz and 4 Hz rises
        restart(STATE_GAME);
        rises = 0;
        p4 = four; p2 = two; p1 = one;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (one && !p1) begin
                rises++;
                chk("align.two",  two  && !p2, 1'b1);
                chk("align.four", four && !p4, 1'b1);
            end
            p4 = four; p2 = two; p1 = one;
        end
        tests++;
        assert (rises == 3) else begin
            errors++;
            $error("FAIL align.count: observed %0d expected 3", rises);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
